// File: rtl/athos_pkg.sv
// rtl/athos_pkg.sv - Shared encodings, instruction views and queue entry type for the ATHOS XIF offload controller.
package athos_pkg;

    // Entry storage is sized for the widest supported configuration; the top truncates.
    localparam int ID_MAX_W = 16;
    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OPC_ATHOS_R = 7'b0001011;
    localparam logic [6:0] OPC_ATHOS_I = 7'b0101011;

    localparam logic [2:0] F3_MONTG     = 3'd0;
    localparam logic [2:0] F3_BARRETT   = 3'd1;
    localparam logic [2:0] F3_CBD       = 3'd2;
    localparam logic [2:0] F3_POLY      = 3'd3;
    localparam logic [2:0] F3_KEM       = 3'd4;
    localparam logic [2:0] F3_LOAD64    = 3'd5;
    localparam logic [2:0] F3_LOAD24_LE = 3'd0;
    localparam logic [2:0] F3_LOAD32_LE = 3'd1;

    localparam logic [1:0] INSR_R = 2'b01;
    localparam logic [1:0] INSR_I = 2'b10;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } athos_r_t;

    typedef struct packed {
        logic [11:0] imm;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } athos_i_t;

    typedef union packed {
        athos_r_t r;
        athos_i_t i;
    } athos_instr_u;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [4:0]          rd;
        logic [2:0]          mode;
        logic [6:0]          funct7;
        logic [11:0]         imm;
        logic [XLEN_MAX-1:0] rs0;
        logic [XLEN_MAX-1:0] rs1;
        logic [1:0]          insr;
        logic                committed;
        logic                killed;
    } athos_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_WAIT,
        ST_RESP
    } athos_state_t;

endpackage

// File: rtl/athos_xif_queue.sv
// rtl/athos_xif_queue.sv - In-order instruction FIFO whose entries are marked committed/killed by id.
module athos_xif_queue
    import athos_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  athos_entry_t                push_entry_i,
    input  logic                        pop_i,
    input  logic                        commit_valid_i,
    input  logic [ID_MAX_W-1:0]         commit_id_i,
    input  logic                        commit_kill_i,
    output athos_entry_t                head_o,
    output logic                        head_valid_o,
    output logic [$clog2(DEPTH):0]      count_o
);

    localparam int PW = $clog2(DEPTH);

    athos_entry_t       mem_q [DEPTH];
    logic [DEPTH-1:0]   vld_q;
    logic [PW-1:0]      wr_q;
    logic [PW-1:0]      rd_q;
    logic [PW:0]        cnt_q;
    logic [PW:0]        cnt_d;
    athos_entry_t       push_upd;

    // A commit/kill for the id being written this cycle must not be lost.
    always_comb begin
        push_upd = push_entry_i;
        if (commit_valid_i && (push_entry_i.id == commit_id_i)) begin
            if (commit_kill_i) push_upd.killed    = 1'b1;
            else               push_upd.committed = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !pop_i)      cnt_d = cnt_q + 1'b1;
        else if (!push_i && pop_i) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            vld_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_valid_i && vld_q[i] && (mem_q[i].id == commit_id_i)) begin
                    if (commit_kill_i) mem_q[i].killed    <= 1'b1;
                    else               mem_q[i].committed <= 1'b1;
                end
            end
            if (push_i) begin
                mem_q[wr_q] <= push_upd;
                vld_q[wr_q] <= 1'b1;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_i) begin
                vld_q[rd_q] <= 1'b0;
                rd_q        <= rd_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

    assign head_o       = mem_q[rd_q];
    assign head_valid_o = vld_q[rd_q];
    assign count_o      = cnt_q;

endmodule

// File: rtl/athos_xif_ooo_ctrl.sv
// rtl/athos_xif_ooo_ctrl.sv - XIF issue/commit front end feeding one accelerator in order; ATHOS_XIF_LOAD64_EN enables LOAD64.
module athos_xif_ooo_ctrl
    import athos_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4,
    parameter int XLEN  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic [31:0]       issue_instr_i,
    input  logic [ID_W-1:0]   issue_id_i,
    input  logic [XLEN-1:0]   issue_rs0_i,
    input  logic [XLEN-1:0]   issue_rs1_i,
    output logic              issue_accept_o,
    output logic              issue_writeback_o,
    output logic              issue_dualwrite_o,
    input  logic              commit_valid_i,
    input  logic [ID_W-1:0]   commit_id_i,
    input  logic              commit_kill_i,
    output logic              acc_valid_o,
    input  logic              acc_ready_i,
    output logic [2:0]        acc_mode_o,
    output logic [6:0]        acc_funct7_o,
    output logic [11:0]       acc_imm_o,
    output logic [XLEN-1:0]   acc_rs1_o,
    output logic [XLEN-1:0]   acc_rs2_o,
    output logic [1:0]        acc_insr_o,
    input  logic              acc_done_i,
    input  logic [2*XLEN-1:0] acc_result_i,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic [ID_W-1:0]   result_id_o,
    output logic [4:0]        result_rd_o,
    output logic              result_we_o,
    output logic [2*XLEN-1:0] result_data_o,
    output logic              busy_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    athos_instr_u      instr;
    logic              is_r;
    logic              is_i;
    logic              dec_ok;
    logic              dec_dual;
    logic              push;
    logic              pop;
    athos_entry_t      push_entry;
    athos_entry_t      head;
    logic              head_valid;
    logic [CW-1:0]     q_count;

    athos_state_t      state_q;
    athos_entry_t      lat_q;
    logic              acc_valid_q;
    logic              result_valid_q;
    logic [2*XLEN-1:0] res_data_q;

    assign instr = issue_instr_i;
    assign is_r  = (instr.r.opcode == OPC_ATHOS_R);
    assign is_i  = (instr.r.opcode == OPC_ATHOS_I);

    always_comb begin
        dec_ok   = 1'b0;
        dec_dual = 1'b0;
        if (is_r) begin
            case (instr.r.funct3)
                F3_MONTG, F3_BARRETT, F3_CBD, F3_POLY, F3_KEM: dec_ok = 1'b1;
`ifdef ATHOS_XIF_LOAD64_EN
                F3_LOAD64: begin
                    dec_ok   = 1'b1;
                    dec_dual = 1'b1;
                end
`endif
                default: dec_ok = 1'b0;
            endcase
        end else if (is_i) begin
            dec_ok = (instr.i.funct3 == F3_LOAD24_LE) || (instr.i.funct3 == F3_LOAD32_LE);
        end
    end

    // Decode is combinational but forced quiet while reset is held.
    assign issue_accept_o    = dec_ok & ~rst_i;
    assign issue_writeback_o = dec_ok & ~rst_i;
`ifdef ATHOS_XIF_LOAD64_EN
    assign issue_dualwrite_o = dec_dual & ~rst_i;
`else
    assign issue_dualwrite_o = 1'b0;
`endif

    assign issue_ready_o = (q_count < CW'(DEPTH));
    assign push          = issue_valid_i & issue_ready_o & issue_accept_o;

    always_comb begin
        push_entry           = '0;
        push_entry.id        = ID_MAX_W'(issue_id_i);
        push_entry.rd        = instr.r.rd;
        push_entry.mode      = instr.r.funct3;
        push_entry.funct7    = is_r ? instr.r.funct7 : 7'd0;
        push_entry.imm       = is_i ? instr.i.imm : 12'd0;
        push_entry.rs0       = XLEN_MAX'(issue_rs0_i);
        push_entry.rs1       = XLEN_MAX'(issue_rs1_i);
        push_entry.insr      = is_r ? INSR_R : INSR_I;
    end

    assign pop = (state_q == ST_IDLE) && head_valid && (head.killed || head.committed);

    athos_xif_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .push_i         (push),
        .push_entry_i   (push_entry),
        .pop_i          (pop),
        .commit_valid_i (commit_valid_i),
        .commit_id_i    (ID_MAX_W'(commit_id_i)),
        .commit_kill_i  (commit_kill_i),
        .head_o         (head),
        .head_valid_o   (head_valid),
        .count_o        (q_count)
    );

    // Once latched, the instruction lives only in lat_q, so later kills cannot reach it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            lat_q          <= '0;
            acc_valid_q    <= 1'b0;
            result_valid_q <= 1'b0;
            res_data_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (head_valid && !head.killed && head.committed) begin
                        lat_q       <= head;
                        acc_valid_q <= 1'b1;
                        state_q     <= ST_DISPATCH;
                    end
                end
                ST_DISPATCH: begin
                    if (acc_ready_i) begin
                        acc_valid_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (acc_done_i) begin
`ifdef ATHOS_XIF_LOAD64_EN
                        res_data_q <= acc_result_i;
`else
                        res_data_q <= {{XLEN{1'b0}}, acc_result_i[XLEN-1:0]};
`endif
                        result_valid_q <= 1'b1;
                        state_q        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (result_ready_i) begin
                        result_valid_q <= 1'b0;
                        state_q        <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign acc_valid_o    = acc_valid_q;
    assign acc_mode_o     = lat_q.mode;
    assign acc_funct7_o   = lat_q.funct7;
    assign acc_imm_o      = lat_q.imm;
    assign acc_rs1_o      = lat_q.rs0[XLEN-1:0];
    assign acc_rs2_o      = lat_q.rs1[XLEN-1:0];
    assign acc_insr_o     = lat_q.insr;
    assign result_valid_o = result_valid_q;
    assign result_we_o    = result_valid_q;
    assign result_id_o    = lat_q.id[ID_W-1:0];
    assign result_rd_o    = lat_q.rd;
    assign result_data_o  = res_data_q;
    assign busy_o         = (q_count != '0) || (state_q != ST_IDLE);

    logic unused_ok;
    assign unused_ok = ^{lat_q, issue_instr_i, acc_result_i};

endmodule

// File: tb/tb_athos_xif_ooo_ctrl.sv
// tb/tb_athos_xif_ooo_ctrl.sv - Scoreboard bench for athos_xif_ooo_ctrl.
module tb_athos_xif_ooo_ctrl;
    import athos_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        issue_valid_i = 1'b0;
    logic        issue_ready_o;
    logic [31:0] issue_instr_i = '0;
    logic [3:0]  issue_id_i = '0;
    logic [31:0] issue_rs0_i = '0;
    logic [31:0] issue_rs1_i = '0;
    logic        issue_accept_o, issue_writeback_o, issue_dualwrite_o;
    logic        commit_valid_i = 1'b0;
    logic [3:0]  commit_id_i = '0;
    logic        commit_kill_i = 1'b0;
    logic        acc_valid_o;
    logic        acc_ready_i = 1'b0;
    logic [2:0]  acc_mode_o;
    logic [6:0]  acc_funct7_o;
    logic [11:0] acc_imm_o;
    logic [31:0] acc_rs1_o, acc_rs2_o;
    logic [1:0]  acc_insr_o;
    logic        acc_done_i = 1'b0;
    logic [63:0] acc_result_i = '0;
    logic        result_valid_o;
    logic        result_ready_i = 1'b0;
    logic [3:0]  result_id_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;
    logic [63:0] result_data_o;
    logic        busy_o;

    athos_xif_ooo_ctrl #(.DEPTH(4), .ID_W(4), .XLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
        .issue_rs0_i(issue_rs0_i), .issue_rs1_i(issue_rs1_i),
        .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
        .issue_dualwrite_o(issue_dualwrite_o),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i), .acc_mode_o(acc_mode_o),
        .acc_funct7_o(acc_funct7_o), .acc_imm_o(acc_imm_o), .acc_rs1_o(acc_rs1_o),
        .acc_rs2_o(acc_rs2_o), .acc_insr_o(acc_insr_o), .acc_done_i(acc_done_i),
        .acc_result_i(acc_result_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_rd_o(result_rd_o), .result_we_o(result_we_o),
        .result_data_o(result_data_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [2:0]  mode;
        logic [1:0]  insr;
        logic [6:0]  f7;
        logic [11:0] imm;
        logic [31:0] rs0;
        logic [31:0] rs1;
        logic [63:0] data;
        logic        we;
    } rec_t;

    rec_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic logic [31:0] mk_r(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] f7);
        return {f7, 5'd2, 5'd1, f3, rd, OPC_ATHOS_R};
    endfunction

    function automatic logic [31:0] mk_i(input logic [2:0] f3, input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd1, f3, rd, OPC_ATHOS_I};
    endfunction

    function automatic logic [63:0] vis(input logic [63:0] r);
`ifdef ATHOS_XIF_LOAD64_EN
        return r;
`else
        return {32'h0, r[31:0]};
`endif
    endfunction

    function automatic rec_t mk_exp(input logic [3:0] id, input logic [4:0] rd, input logic [2:0] mode,
                                    input logic [1:0] insr, input logic [6:0] f7, input logic [11:0] imm,
                                    input logic [31:0] r0, input logic [31:0] r1, input logic [63:0] res);
        rec_t e;
        e.id = id; e.rd = rd; e.mode = mode; e.insr = insr; e.f7 = f7; e.imm = imm;
        e.rs0 = r0; e.rs1 = r1; e.data = vis(res); e.we = 1'b1;
        return e;
    endfunction

    task automatic do_issue(input logic [31:0] ins, input logic [3:0] id, input logic [31:0] r0,
                            input logic [31:0] r1, input bit cmt,
                            output logic acc, output logic wb, output logic dw, output logic rdy);
        issue_valid_i = 1'b1; issue_instr_i = ins; issue_id_i = id;
        issue_rs0_i = r0; issue_rs1_i = r1;
        if (cmt) begin
            commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = 1'b0;
        end
        #1;
        acc = issue_accept_o; wb = issue_writeback_o; dw = issue_dualwrite_o; rdy = issue_ready_o;
        @(negedge clk_i);
        issue_valid_i = 1'b0; issue_instr_i = '0; commit_valid_i = 1'b0;
    endtask

    task automatic do_commit(input logic [3:0] id, input logic kill);
        commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
        @(negedge clk_i);
        commit_valid_i = 1'b0; commit_kill_i = 1'b0;
    endtask

    // Plays the accelerator and the result consumer for one instruction; reports what it saw.
    task automatic run_one(input logic [63:0] res, output rec_t o, output int lat, output bit to);
        to = 1'b0; lat = 0; o = '0;
        for (int k = 0; k < 20 && !acc_valid_o; k++) @(negedge clk_i);
        if (!acc_valid_o) begin
            to = 1'b1;
            return;
        end
        o.mode = acc_mode_o; o.insr = acc_insr_o; o.f7 = acc_funct7_o; o.imm = acc_imm_o;
        o.rs0 = acc_rs1_o; o.rs1 = acc_rs2_o;
        acc_ready_i = 1'b1;
        @(negedge clk_i);
        acc_ready_i = 1'b0; acc_done_i = 1'b1; acc_result_i = res;
        @(negedge clk_i);
        acc_done_i = 1'b0; acc_result_i = '0;
        for (int k = 0; k < 5 && !result_valid_o; k++) begin
            @(negedge clk_i);
            lat++;
        end
        if (!result_valid_o) begin
            to = 1'b1;
            return;
        end
        o.id = result_id_o; o.rd = result_rd_o; o.data = result_data_o; o.we = result_we_o;
        result_ready_i = 1'b1;
        @(negedge clk_i);
        result_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        issue_valid_i = 1'b1; issue_instr_i = mk_r(F3_MONTG, 5'd1, 7'd0);
        repeat (2) @(negedge clk_i);
        #1;
        n_total++; if (issue_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", issue_ready_o); else n_pass++;
        n_total++; if ({issue_accept_o, issue_writeback_o, issue_dualwrite_o} !== 3'b000)
            $display("FAIL reset_accept: got %b want 000", {issue_accept_o, issue_writeback_o, issue_dualwrite_o}); else n_pass++;
        n_total++; if ({acc_valid_o, result_valid_o, result_we_o, busy_o} !== 4'b0000)
            $display("FAIL reset_valids: got %b want 0000", {acc_valid_o, result_valid_o, result_we_o, busy_o}); else n_pass++;
        n_total++; if ({acc_mode_o, acc_rs1_o, result_data_o, result_id_o} !== '0)
            $display("FAIL reset_fields: got %h want 0", {acc_mode_o, acc_rs1_o, result_data_o, result_id_o}); else n_pass++;
        @(negedge clk_i);
        rst_i = 1'b0; issue_valid_i = 1'b0; issue_instr_i = '0;
        @(negedge clk_i);
    endtask

    task automatic test_basic();
        logic a, w, d, r; rec_t o, e; int lat; bit to;
        sb.push_back(mk_exp(4'd3, 5'd5, F3_MONTG, INSR_R, 7'h0A, 12'h0, 32'h11, 32'h22, 64'h99));
        do_issue(mk_r(F3_MONTG, 5'd5, 7'h0A), 4'd3, 32'h11, 32'h22, 1'b0, a, w, d, r);
        n_total++; if ({a, w, d} !== 3'b110) $display("FAIL basic_decode: got %b want 110", {a, w, d}); else n_pass++;
        do_commit(4'd3, 1'b0);
        run_one(64'h99, o, lat, to);
        e = sb.pop_front();
        n_total++; if (to) $display("FAIL basic_timeout: got timeout want handshake"); else n_pass++;
        n_total++; if (o !== e) $display("FAIL basic_result: got %h want %h", o, e); else n_pass++;
        n_total++; if (lat !== 0) $display("FAIL basic_latency: got %0d want 0", lat); else n_pass++;
    endtask

    task automatic test_full();
        logic a, w, d, r; rec_t o, e; int lat; bit to;
        logic [31:0] ins [4];
        logic [63:0] res [4];
        ins[0] = mk_r(F3_CBD, 5'd6, 7'h11);    res[0] = 64'hABCD_0000_1234_5678;
        ins[1] = mk_r(F3_POLY, 5'd7, 7'h22);   res[1] = 64'h0000_0000_0000_0777;
        ins[2] = mk_i(F3_LOAD24_LE, 5'd8, 12'h123); res[2] = 64'h1_0000_0888;
        ins[3] = mk_r(F3_BARRETT, 5'd9, 7'h33); res[3] = 64'h0000_0000_CAFE_F00D;
        sb.push_back(mk_exp(4'd4, 5'd6, F3_CBD, INSR_R, 7'h11, 12'h0, 32'h40, 32'h41, res[0]));
        sb.push_back(mk_exp(4'd5, 5'd7, F3_POLY, INSR_R, 7'h22, 12'h0, 32'h50, 32'h51, res[1]));
        sb.push_back(mk_exp(4'd6, 5'd8, F3_LOAD24_LE, INSR_I, 7'h0, 12'h123, 32'h60, 32'h61, res[2]));
        sb.push_back(mk_exp(4'd7, 5'd9, F3_BARRETT, INSR_R, 7'h33, 12'h0, 32'h70, 32'h71, res[3]));
        for (int i = 0; i < 4; i++)
            do_issue(ins[i], 4'(4 + i), 32'(8'h40 + 16 * i), 32'(8'h41 + 16 * i), 1'b0, a, w, d, r);
        #1;
        n_total++; if ({issue_ready_o, busy_o} !== 2'b01) $display("FAIL full_ready: got %b want 01", {issue_ready_o, busy_o}); else n_pass++;
        do_issue(mk_r(F3_KEM, 5'd10, 7'h0), 4'd8, 32'h80, 32'h81, 1'b0, a, w, d, r);
        n_total++; if ({a, r} !== 2'b10) $display("FAIL full_fifth: got accept/ready %b want 10", {a, r}); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            do_commit(4'(4 + i), 1'b0);
            run_one(res[i], o, lat, to);
            e = sb.pop_front();
            n_total++; if (to || o !== e) $display("FAIL full_result%0d: got %h (to=%0b) want %h", i, o, to, e); else n_pass++;
            if (i == 0) begin
                #1;
                n_total++; if (issue_ready_o !== 1'b1) $display("FAIL full_ready_back: got %b want 1", issue_ready_o); else n_pass++;
            end
        end
        #1;
        n_total++; if (busy_o !== 1'b0) $display("FAIL full_drained: got busy %b want 0", busy_o); else n_pass++;
    endtask

    task automatic test_kill();
        logic a, w, d, r; rec_t o, e; int lat; bit to;
        sb.push_back(mk_exp(4'd2, 5'd12, F3_POLY, INSR_R, 7'h05, 12'h0, 32'h200, 32'h201, 64'h2222));
        do_issue(mk_r(F3_MONTG, 5'd11, 7'h04), 4'd1, 32'h100, 32'h101, 1'b0, a, w, d, r);
        do_issue(mk_r(F3_POLY, 5'd12, 7'h05), 4'd2, 32'h200, 32'h201, 1'b0, a, w, d, r);
        do_commit(4'd1, 1'b1);
        do_commit(4'd2, 1'b0);
        #1;
        n_total++; if (acc_valid_o !== 1'b0) $display("FAIL kill_early: got acc_valid %b want 0", acc_valid_o); else n_pass++;
        @(negedge clk_i); #1;
        n_total++; if (acc_valid_o !== 1'b1) $display("FAIL kill_drop_cycle: got acc_valid %b want 1", acc_valid_o); else n_pass++;
        run_one(64'h2222, o, lat, to);
        e = sb.pop_front();
        n_total++; if (to || o !== e) $display("FAIL kill_result: got %h (to=%0b) want %h", o, to, e); else n_pass++;
        #1;
        n_total++; if (busy_o !== 1'b0) $display("FAIL kill_busy: got %b want 0", busy_o); else n_pass++;
    endtask

    task automatic test_reject();
        logic a, w, d, r;
        logic [31:0] bad [4];
        bad[0] = mk_r(3'd6, 5'd1, 7'd0);
        bad[1] = mk_r(3'd7, 5'd1, 7'd0);
        bad[2] = mk_i(3'd3, 5'd1, 12'd5);
        bad[3] = {7'd0, 5'd2, 5'd1, 3'd0, 5'd1, 7'b0110011};
        for (int i = 0; i < 4; i++) begin
            do_issue(bad[i], 4'(i), 32'h1, 32'h2, 1'b1, a, w, d, r);
            n_total++; if ({a, w, d} !== 3'b000) $display("FAIL reject%0d: got %b want 000", i, {a, w, d}); else n_pass++;
        end
        #1;
        n_total++; if ({busy_o, acc_valid_o} !== 2'b00) $display("FAIL reject_count: got %b want 00", {busy_o, acc_valid_o}); else n_pass++;
    endtask

    task automatic test_load64();
        logic a, w, d, r;
`ifdef ATHOS_XIF_LOAD64_EN
        rec_t o, e; int lat; bit to;
        sb.push_back(mk_exp(4'd10, 5'd13, F3_LOAD64, INSR_R, 7'h01, 12'h0, 32'hA0, 32'hA1, 64'h1122_3344_5566_7788));
        do_issue(mk_r(F3_LOAD64, 5'd13, 7'h01), 4'd10, 32'hA0, 32'hA1, 1'b1, a, w, d, r);
        n_total++; if ({a, w, d} !== 3'b111) $display("FAIL load64_decode: got %b want 111", {a, w, d}); else n_pass++;
        run_one(64'h1122_3344_5566_7788, o, lat, to);
        e = sb.pop_front();
        n_total++; if (to || o !== e) $display("FAIL load64_result: got %h (to=%0b) want %h", o, to, e); else n_pass++;
`else
        do_issue(mk_r(F3_LOAD64, 5'd13, 7'h01), 4'd10, 32'hA0, 32'hA1, 1'b1, a, w, d, r);
        n_total++; if ({a, w, d} !== 3'b000) $display("FAIL load64_decode: got %b want 000", {a, w, d}); else n_pass++;
        #1;
        n_total++; if (busy_o !== 1'b0) $display("FAIL load64_busy: got %b want 0", busy_o); else n_pass++;
`endif
    endtask

    task automatic test_stall_reset();
        logic a, w, d, r; rec_t e;
        e = mk_exp(4'd9, 5'd14, F3_CBD, INSR_R, 7'h09, 12'h0, 32'h90, 32'h91, 64'h5555);
        do_issue(mk_r(F3_CBD, 5'd14, 7'h09), 4'd9, 32'h90, 32'h91, 1'b1, a, w, d, r);
        for (int k = 0; k < 20 && !acc_valid_o; k++) @(negedge clk_i);
        n_total++; if (acc_valid_o !== 1'b1) $display("FAIL stall_dispatch: got %b want 1", acc_valid_o); else n_pass++;
        acc_ready_i = 1'b1;
        @(negedge clk_i);
        acc_ready_i = 1'b0;
        do_commit(4'd9, 1'b1);
        acc_done_i = 1'b1; acc_result_i = 64'h5555;
        @(negedge clk_i);
        acc_done_i = 1'b0; acc_result_i = '0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_total++;
            if ({result_valid_o, result_we_o, result_id_o, result_rd_o, result_data_o} !== {2'b11, e.id, e.rd, e.data})
                $display("FAIL stall_hold%0d: got %h want %h", k,
                         {result_valid_o, result_we_o, result_id_o, result_rd_o, result_data_o}, {2'b11, e.id, e.rd, e.data});
            else n_pass++;
            @(negedge clk_i);
        end
        result_ready_i = 1'b1;
        @(negedge clk_i);
        result_ready_i = 1'b0; #1;
        n_total++; if (result_valid_o !== 1'b0) $display("FAIL stall_release: got %b want 0", result_valid_o); else n_pass++;
        do_issue(mk_r(F3_KEM, 5'd15, 7'h0C), 4'd12, 32'hC0, 32'hC1, 1'b1, a, w, d, r);
        do_issue(mk_r(F3_POLY, 5'd16, 7'h0D), 4'd11, 32'hD0, 32'hD1, 1'b1, a, w, d, r);
        for (int k = 0; k < 20 && !acc_valid_o; k++) @(negedge clk_i);
        acc_ready_i = 1'b1;
        @(negedge clk_i);
        acc_ready_i = 1'b0;
        rst_i = 1'b1; #1;
        n_total++;
        if ({issue_accept_o, issue_writeback_o, issue_dualwrite_o, acc_valid_o, acc_mode_o, acc_funct7_o, acc_imm_o,
             acc_rs1_o, acc_rs2_o, acc_insr_o, result_valid_o, result_id_o, result_rd_o, result_we_o,
             result_data_o, busy_o} !== '0)
            $display("FAIL wait_reset_outputs: got nonzero, busy=%b acc_valid=%b mode=%h", busy_o, acc_valid_o, acc_mode_o);
        else n_pass++;
        n_total++; if (issue_ready_o !== 1'b1) $display("FAIL wait_reset_ready: got %b want 1", issue_ready_o); else n_pass++;
        @(negedge clk_i);
        rst_i = 1'b0; acc_done_i = 1'b1; acc_result_i = 64'hDEAD;
        @(negedge clk_i);
        acc_done_i = 1'b0; acc_result_i = '0;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_total++;
            if ({result_valid_o, acc_valid_o, busy_o} !== 3'b000)
                $display("FAIL post_reset%0d: got %b want 000", k, {result_valid_o, acc_valid_o, busy_o});
            else n_pass++;
            @(negedge clk_i);
        end
    endtask

    task automatic test_back_to_back();
        logic a, w, d, r; rec_t o, e; int lat; bit to;
        logic [63:0] res;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk_exp(4'(13 + i), 5'(20 + i), 3'(i), INSR_R, 7'(i + 1), 12'h0,
                                32'(1000 + i), 32'(2000 + i), 64'(64'h1_0000_0000 * i + 64'h300 + i)));
            do_issue(mk_r(3'(i), 5'(20 + i), 7'(i + 1)), 4'(13 + i), 32'(1000 + i), 32'(2000 + i), 1'b1, a, w, d, r);
        end
        for (int i = 0; i < 3; i++) begin
            res = 64'(64'h1_0000_0000 * i + 64'h300 + i);
            run_one(res, o, lat, to);
            e = sb.pop_front();
            n_total++; if (to || o !== e) $display("FAIL b2b_result%0d: got %h (to=%0b) want %h", i, o, to, e); else n_pass++;
        end
        #1;
        n_total++; if (busy_o !== 1'b0) $display("FAIL b2b_busy: got %b want 0", busy_o); else n_pass++;
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_basic();
        test_full();
        test_kill();
        test_reject();
        test_load64();
        test_stall_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule
